// File: rtl/dm_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] BCD_NINE    = 4'h9;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/dm_bcd_add3.sv
// Conditional +3 on one BCD nibble (double-dabble correction step).
// Purely combinational, zero latency, no flow control.
module dm_bcd_add3
  import dm_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Input nibble is <= 9 in normal operation, so the 4-bit sum never wraps.
  assign nib_o = (nib_i >= ADD3_THRESH) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/dm_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, with blanking and saturation.
// Result and done appear DATA_W+1 cycles after the accepted start; start outside IDLE is dropped.
module dm_bcd_seq
  import dm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  ovf
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int ACC_W = 4 * DIGITS;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic                blank_q, blank_d;
  logic [ACC_W-1:0]    bcd_q, bcd_d;
  logic [DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                ovf_q, ovf_d;

  logic [ACC_W-1:0]    acc_adj;
  logic [ACC_W-1:0]    acc_shift;
  logic [DIGITS-1:0]   lz_en;
  logic                ovf_next;
  logic                seen_nz;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    dm_bcd_add3 u_add3 (
      .nib_i (acc_q[4*g +: 4]),
      .nib_o (acc_adj[4*g +: 4])
    );
  end

  assign acc_shift = {acc_adj[ACC_W-2:0], bin_q[DATA_W-1]};
  assign ovf_next  = ovf_acc_q | acc_adj[ACC_W-1];

  // Digit i is shown when it or any higher digit is nonzero; units always shown.
  always_comb begin
    lz_en   = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen_nz  = seen_nz | (acc_shift[4*i +: 4] != 4'd0);
      lz_en[i] = seen_nz | (i == 0);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    blank_d   = blank_q;
    bcd_d     = bcd_q;
    dig_en_d  = dig_en_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = data_in;
          blank_d   = blank_lz;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CNT_W'(DATA_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        acc_d     = acc_shift;
        bin_d     = {bin_q[DATA_W-2:0], 1'b0};
        ovf_acc_d = ovf_next;
        cnt_d     = cnt_q - CNT_W'(1);
        // Result registers load on entry to DONE so they are valid during the done pulse.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          if (ovf_next) begin
            bcd_d    = {DIGITS{BCD_NINE}};
            dig_en_d = '1;
            ovf_d    = 1'b1;
          end else begin
            bcd_d    = acc_shift;
            dig_en_d = blank_q ? lz_en : '1;
            ovf_d    = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      blank_q   <= 1'b0;
      bcd_q     <= '0;
      dig_en_q  <= DIGITS'(1);
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      blank_q   <= blank_d;
      bcd_q     <= bcd_d;
      dig_en_q  <= dig_en_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign bcd    = bcd_q;
  assign dig_en = dig_en_q;
  assign ovf    = ovf_q;

endmodule

// File: doc/dm_bcd_seq.md
Name: dm_bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter for the display path. Replaces combinational divide/modulo digit extraction.
- Uses iterative shift-add-3 (double dabble): one input bit per clock.
- Provides start/busy/done handshake, leading-zero blanking and overflow saturation.
- Sits between the datapath and the 7-segment display driver. bcd/dig_en feed the driver's per-digit enable/value fields.

Parameters:
- DATA_W, 16, width of the binary input (>= 4).
- DIGITS, 5, number of BCD output digits (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request conversion of data_in. Sampled only in IDLE.
- data_in  in  DATA_W  unsigned binary value. Latched on accepted start.
- blank_lz  in  1  leading-zero blank enable. Latched on accepted start.
- busy  out  1  high while iterating (SHIFT state).
- done  out  1  one-cycle pulse when a new result is presented.
- bcd  out  4*DIGITS  digit i at bits [4i+3:4i], digit 0 = units.
- dig_en  out  DIGITS  per-digit display enable.
- ovf  out  1  data_in >= 10^DIGITS for the last completed conversion.

Behaviour:
- Reset (all synchronous, rst=1 at rising edge):
  - State goes to IDLE.
  - Outputs: busy=0, done=0, bcd=0, dig_en=1 on digit 0 only, ovf=0.
  - The iteration counter and shift registers are cleared.
  - Reset mid-conversion aborts it. No done pulse. Outputs take their reset values.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on start=1, latch data_in into the binary shift register and blank_lz. Clear the BCD accumulator and overflow flag. Load counter=DATA_W. Go to SHIFT.
  - SHIFT: one iteration per cycle:
    - Every nibble >= 5 gets +3 (all nibbles in parallel).
    - Then shift left {bcd_acc, bin} by 1.
    - The bit shifted out of the top nibble ORs into the internal overflow flag.
    - Counter decrements. The iteration with counter==1 is the last; then go to DONE.
  - DONE: update the bcd/dig_en/ovf registers, done=1 for exactly this cycle, then go to IDLE.
- Latency:
  - start is sampled at edge k.
  - busy=1 in the DATA_W cycles following edges k..k+DATA_W-1.
  - done=1 in the cycle following edge k+DATA_W.
  - A new start can be accepted at edge k+DATA_W+2 at the earliest.
- start while busy or in DONE is ignored, not queued. data_in changes during a conversion have no effect.
- Outputs hold the last result until the next DONE or reset. They never show intermediate accumulator values.
- Overflow: if the flag is set, bcd is saturated to all nines (every nibble 4'h9), dig_en is all ones and ovf=1. Otherwise ovf=0.
- Blanking, applied when not overflowed:
  - blank_lz=1: dig_en[i]=0 for every digit above the most-significant nonzero digit. Digit 0 is always enabled, so a value of 0 shows a single "0".
  - blank_lz=0: dig_en all ones.
- Width rules:
  - Counter width is $clog2(DATA_W+1).
  - Accumulator is 4*DIGITS bits. The add-3 result is computed in 4 bits; it cannot exceed 12 because the input nibble is <= 9.
- simultaneous start and rst: rst wins.

Decomposition:
- Shared package dm_pkg:
  - state enum (IDLE, SHIFT, DONE)
  - constant BCD_NINE = 4'h9
  - constant ADD3_THRESH = 4'd5
- One sub-module dm_bcd_add3: 4-bit combinational conditional +3. Instantiated DIGITS times in a generate loop.
- All registers, FSM, counter, blanking and saturation logic stay in dm_bcd_seq.

Test Plan:
- Defaults, data_in=0, blank_lz=1 -> after done: bcd=20'h00000, dig_en=5'b00001, ovf=0.
- Defaults, data_in=65535, blank_lz=0 -> bcd=20'h65535, dig_en=5'b11111, ovf=0. done exactly 17 cycles after the start edge; busy high 16 cycles.
- Defaults, data_in=1234, blank_lz=1 -> bcd=20'h01234, dig_en=5'b01111. Same value with blank_lz=0 -> dig_en=5'b11111.
- DIGITS=4, data_in=10000 -> bcd=16'h9999, dig_en=4'b1111, ovf=1. Then data_in=9999 -> bcd=16'h9999, ovf=0.
- Start 42, then pulse start with data_in=777 at cycle 5 -> second start ignored. Result is 42; no second done.
- Start 500, assert rst at cycle 8 -> no done, outputs at reset values. Then start 500 -> bcd=20'h00500 after 17 cycles.
